jk_seq_ctrl: RTL and testbench
==============================

# jk_seq_ctrl

Sequencing controller for a WIDTH-bit register built from JK flip-flop cells. It turns a start/mode/length command into per-bit J/K excitation so the register counts up, down, in Gray code or ping-pong for a programmed number of steps. It reports busy/done to the issuing logic. It sits between command logic and the JK-cell counter bank, which it instantiates and owns.

## Interface
Parameters:
- WIDTH, 4, register and step-counter width (2..16)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  command strobe, sampled only in IDLE
- mode  in  2  00 up, 01 down, 10 Gray up, 11 ping-pong; latched on accepted start
- load_val  in  WIDTH  initial register value, latched on accepted start
- limit  in  WIDTH  number of steps to run, latched on accepted start
- step_en  in  1  advance permission in RUN; low = hold
- abort  in  1  synchronous cancel from LOAD/RUN
- q  out  WIDTH  current register value (JK cell outputs)
- busy  out  1  high in LOAD and RUN
- done  out  1  one-cycle pulse in DONE

## Operation
- States: IDLE, LOAD, RUN, DONE; reset → IDLE.
- IDLE: start=1 latches mode, load_val and limit, clears the step counter, and moves to LOAD. Otherwise q holds.
- LOAD: the JK bank is excited to reach load_val in one edge. The dir flag is set to up. Next state is RUN, or DONE if latched limit = 0.
- RUN: each cycle with step_en=1 the register moves to next(q) and steps increments. When steps reaches limit-1 with step_en=1, the last step occurs and the state goes to DONE. With step_en=0 both q and steps hold.
- DONE: done=1 for exactly one cycle, then IDLE. q holds the final value.
- abort=1 in LOAD or RUN → IDLE on the next edge, with no done pulse. q keeps its value as of that edge, and no step is taken on that edge. abort takes priority over step_en. abort is ignored in IDLE and DONE.
- start outside IDLE is ignored. That includes DONE: a new command needs a start in IDLE.
- Excitation for target n versus current q, per bit i:
  - J_i = n_i & ~q_i
  - K_i = q_i & ~n_i
  - Unchanged bits get JK=00 (hold).
- next(q), modulo 2^WIDTH:
  - up: q+1
  - down: q-1
  - Gray: gray(bin(q)+1), where bin() is Gray-to-binary and gray(b) = b ^ (b>>1). Register contents are Gray code.
  - ping-pong: q+1 while dir=up, q-1 while dir=down. dir flips to down on the step that reaches all-ones and to up on the step that reaches 0. If load_val = all-ones, the first step goes down.
- Wrap: up from all-ones → 0; down from 0 → all-ones. No flag is raised.

## Timing
- Reset values: q=0, busy=0, done=0, state IDLE, steps=0, dir=up.
- start accepted at edge E0 → LOAD during cycle 1; q = load_val after edge E1; RUN from cycle 2.
- Latency from start to done, with step_en held high and limit=L≥1: done is high in cycle L+2 after the start edge.
- limit=0: done is high in cycle 2 and q = load_val.
- busy rises the cycle after start is accepted and falls in the DONE cycle.
- Reset asserted mid-operation clears q and all state immediately, independent of clk.

## Configuration
- JK_SEQ_GRAY_EN defined: mode 10 runs the Gray sequence as above.
- JK_SEQ_GRAY_EN undefined: no Gray conversion logic is built, and mode 10 behaves exactly as mode 00 (binary up).

## Structure
- Shared package jk_seq_pkg holds:
  - state enum (IDLE, LOAD, RUN, DONE)
  - mode constants MODE_UP, MODE_DOWN, MODE_GRAY, MODE_PP
  - Gray/binary conversion functions
- Sub-module jk_cell: one JK flip-flop with asynchronous active-high reset to 0, rising-edge clk.
  - 00 hold, 01 clear, 10 set, 11 toggle.
  - The controller instantiates WIDTH of them; q is their concatenated output.

## Test plan
- WIDTH=4, mode 00, load_val=4'hE, limit=3, step_en=1 → q goes E,F,0,1; done pulses once; busy covers LOAD+RUN.
- mode 01, load_val=1, limit=3 → q goes 1,0,F,E; done after the 3rd step.
- mode 11, load_val=4'hD, limit=5 → q goes D,E,F,E,D,C; dir flips at F.
- mode 10 with JK_SEQ_GRAY_EN, load_val=0, limit=4 → q goes 0,1,3,2,6. Without the macro the same stimulus gives 0,1,2,3,4.
- limit=0 → done in cycle 2 and q=load_val. A later test toggles step_en mid-RUN: q holds while step_en is low.
- abort in RUN after 2 steps → IDLE, no done, q frozen. A separate run asserts reset mid-RUN: q=0 asynchronously, and a start during RUN is ignored.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared types and helpers for the JK-cell sequencing controller:
// controller state encoding, mode codes and Gray/binary conversion.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_GRAY = 2'b10;
  localparam logic [1:0] MODE_PP   = 2'b11;

  // Converters work on the widest supported register (16 bits). Narrower
  // callers zero-extend on the way in and truncate on the way out. Zero
  // upper bits convert to zero upper bits, so narrow values are unaffected.
  function automatic logic [15:0] gray2bin(input logic [15:0] g);
    logic [15:0] b;
    b[15] = g[15];
    for (int i = 14; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [15:0] bin2gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/jk_seq_ctrl_if.sv
// Command/status bundle between the issuing logic (master) and the
// JK sequencing controller (slave).
interface jk_seq_ctrl_if #(parameter int WIDTH = 4);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic             step_en;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, load_val, limit, step_en, abort,
    input  q, busy, done
  );

  modport slave (
    input  start, mode, load_val, limit, step_en, abort,
    output q, busy, done
  );
endinterface

// File: rtl/jk_seq_ctrl_jk_cell.sv
// Single JK flip-flop: 00 hold, 01 clear, 10 set, 11 toggle.
// Asynchronous active-high reset to 0.
module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK excitation applied on each rising edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_seq_ctrl.sv
// Sequencing controller for a WIDTH-bit JK-cell register. Accepts a
// start/mode/load/limit command, loads the register, then steps it up,
// down, in Gray code or ping-pong for the programmed number of steps.
// Optional feature macro: JK_SEQ_GRAY_EN builds the Gray stepping path;
// without it mode 10 steps as plain binary up.
module jk_seq_ctrl
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  jk_seq_ctrl_if.slave   bus
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  state_t           state, state_nxt;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] load_r;
  logic [WIDTH-1:0] limit_r;
  logic [WIDTH-1:0] steps;
  logic             dir_up;

  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] j_w, k_w;
  logic             eff_up;
  logic             step;
  logic             last_step;

  assign step      = (state == RUN) && bus.step_en && !bus.abort;
  assign last_step = (steps == (limit_r - ONE));

`ifdef JK_SEQ_GRAY_EN
  logic [WIDTH-1:0] gray_bin;
  logic [WIDTH-1:0] gray_nxt;
  assign gray_bin = WIDTH'(gray2bin(16'(q_w))) + ONE;
  assign gray_nxt = WIDTH'(bin2gray(16'(gray_bin)));
`endif

  // Successor value of the register for the latched mode; ping-pong
  // turns around at the ends even when loaded at an end value
  always_comb begin
    eff_up = dir_up;
    if (q_w == ONES) begin
      eff_up = 1'b0;
    end else if (q_w == '0) begin
      eff_up = 1'b1;
    end
    case (mode_r)
      MODE_DOWN: next_q = q_w - ONE;
      MODE_PP:   next_q = eff_up ? (q_w + ONE) : (q_w - ONE);
`ifdef JK_SEQ_GRAY_EN
      MODE_GRAY: next_q = gray_nxt;
`endif
      default:   next_q = q_w + ONE;
    endcase
  end

  // Target register value for this edge and its per-bit JK excitation
  always_comb begin
    target = q_w;
    case (state)
      LOAD:    if (!bus.abort) target = load_r;
      RUN:     if (step) target = next_q;
      default: target = q_w;
    endcase
    j_w = target & ~q_w;
    k_w = q_w & ~target;
  end

  // Next-state decode; abort wins over stepping in LOAD and RUN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = LOAD;
      LOAD: begin
        if (bus.abort)          state_nxt = IDLE;
        else if (limit_r == '0) state_nxt = DONE;
        else                    state_nxt = RUN;
      end
      RUN: begin
        if (bus.abort)                     state_nxt = IDLE;
        else if (bus.step_en && last_step) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command latch, step counter and ping-pong direction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_r  <= MODE_UP;
      load_r  <= '0;
      limit_r <= '0;
      steps   <= '0;
      dir_up  <= 1'b1;
    end else begin
      if (state == IDLE && bus.start) begin
        mode_r  <= bus.mode;
        load_r  <= bus.load_val;
        limit_r <= bus.limit;
        steps   <= '0;
      end
      if (state == LOAD) begin
        dir_up <= 1'b1;
      end
      if (step) begin
        steps <= steps + ONE;
        if (mode_r == MODE_PP) begin
          if (next_q == ONES)    dir_up <= 1'b0;
          else if (next_q == '0) dir_up <= 1'b1;
          else                   dir_up <= eff_up;
        end
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j_w[i]),
      .k     (k_w[i]),
      .q     (q_w[i])
    );
  end

  assign bus.q    = q_w;
  assign bus.busy = (state == LOAD) || (state == RUN);
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Directed bench for jk_seq_ctrl at WIDTH=4. Inputs change on the falling
// edge and outputs are sampled on the falling edge.
module tb_jk_seq_ctrl;

  localparam int WIDTH = 4;

  logic clk;
  logic reset;
  int   vec;
  int   errs;

  jk_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  jk_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue a command: start is seen by edge E0, and the call returns just
  // after E0. The command fields are then scrambled to prove they were latched.
  task automatic issue(input logic [1:0] m, input logic [3:0] lv, input logic [3:0] lim);
    @(negedge clk);
    bus.mode     = m;
    bus.load_val = lv;
    bus.limit    = lim;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.mode     = ~m;
    bus.load_val = ~lv;
    bus.limit    = ~lim;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.mode = 2'b00; bus.load_val = '0; bus.limit = '0;
    bus.step_en = 1'b1; bus.abort = 1'b0;
    #12;
    vec++; if (bus.q !== 4'h0) begin errs++; $display("FAIL reset_q: got %h want 0", bus.q); end
    vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errs++; $display("FAIL reset_flags: busy=%b done=%b want 0 0", bus.busy, bus.done); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vec++; if (bus.q !== 4'h0 || bus.busy !== 1'b0) begin
      errs++; $display("FAIL idle_after_reset: q=%h busy=%b want 0 0", bus.q, bus.busy); end
  endtask

  task automatic test_up();
    logic [3:0] e [0:3];
    e = '{4'hE, 4'hF, 4'h0, 4'h1};
    issue(2'b00, 4'hE, 4'd3);
    @(negedge clk);
    vec++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errs++; $display("FAIL up_load: busy=%b done=%b want 1 0", bus.busy, bus.done); end
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      vec++; if (bus.q !== e[c]) begin errs++; $display("FAIL up_q[%0d]: got %h want %h", c, bus.q, e[c]); end
      vec++; if (bus.done !== (c == 3) || bus.busy !== (c < 3)) begin
        errs++; $display("FAIL up_flags[%0d]: busy=%b done=%b", c, bus.busy, bus.done); end
    end
    @(negedge clk);
    vec++; if (bus.done !== 1'b0 || bus.q !== 4'h1) begin
      errs++; $display("FAIL up_after: done=%b q=%h want 0 1", bus.done, bus.q); end
  endtask

  task automatic test_down();
    logic [3:0] e [0:3];
    e = '{4'h1, 4'h0, 4'hF, 4'hE};
    issue(2'b01, 4'h1, 4'd3);
    @(negedge clk);
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      vec++; if (bus.q !== e[c]) begin errs++; $display("FAIL down_q[%0d]: got %h want %h", c, bus.q, e[c]); end
      vec++; if (bus.done !== (c == 3)) begin errs++; $display("FAIL down_done[%0d]: got %b", c, bus.done); end
    end
    @(negedge clk);
  endtask

  task automatic test_pingpong();
    logic [3:0] e [0:5];
    e = '{4'hD, 4'hE, 4'hF, 4'hE, 4'hD, 4'hC};
    issue(2'b11, 4'hD, 4'd5);
    @(negedge clk);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      vec++; if (bus.q !== e[c]) begin errs++; $display("FAIL pp_q[%0d]: got %h want %h", c, bus.q, e[c]); end
      vec++; if (bus.done !== (c == 5)) begin errs++; $display("FAIL pp_done[%0d]: got %b", c, bus.done); end
    end
    @(negedge clk);
  endtask

  task automatic test_gray();
    logic [3:0] e [0:4];
`ifdef JK_SEQ_GRAY_EN
    e = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6};
`else
    e = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
`endif
    issue(2'b10, 4'h0, 4'd4);
    @(negedge clk);
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      vec++; if (bus.q !== e[c]) begin errs++; $display("FAIL gray_q[%0d]: got %h want %h", c, bus.q, e[c]); end
      vec++; if (bus.done !== (c == 4)) begin errs++; $display("FAIL gray_done[%0d]: got %b", c, bus.done); end
    end
    @(negedge clk);
  endtask

  task automatic test_limit_zero();
    issue(2'b00, 4'h7, 4'd0);
    @(negedge clk);
    vec++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errs++; $display("FAIL lim0_load: busy=%b done=%b want 1 0", bus.busy, bus.done); end
    @(negedge clk);
    vec++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.q !== 4'h7) begin
      errs++; $display("FAIL lim0_done: done=%b busy=%b q=%h want 1 0 7", bus.done, bus.busy, bus.q); end
    @(negedge clk);
    vec++; if (bus.done !== 1'b0 || bus.q !== 4'h7) begin
      errs++; $display("FAIL lim0_after: done=%b q=%h want 0 7", bus.done, bus.q); end
  endtask

  task automatic test_step_hold();
    logic [3:0] e [0:5];
    logic       d [0:5];
    e = '{4'h3, 4'h3, 4'h3, 4'h4, 4'h5, 4'h6};
    d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    issue(2'b00, 4'h3, 4'd3);
    @(negedge clk);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      vec++; if (bus.q !== e[c]) begin errs++; $display("FAIL hold_q[%0d]: got %h want %h", c, bus.q, e[c]); end
      vec++; if (bus.done !== d[c]) begin errs++; $display("FAIL hold_done[%0d]: got %b want %b", c, bus.done, d[c]); end
      bus.step_en = (c >= 2);
    end
    bus.step_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abort();
    issue(2'b00, 4'h5, 4'd6);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    vec++; if (bus.q !== 4'h7) begin errs++; $display("FAIL abort_pre: got %h want 7", bus.q); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    vec++; if (bus.q !== 4'h7 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errs++; $display("FAIL abort_edge: q=%h busy=%b done=%b want 7 0 0", bus.q, bus.busy, bus.done); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vec++; if (bus.q !== 4'h7 || bus.done !== 1'b0) begin
        errs++; $display("FAIL abort_idle[%0d]: q=%h done=%b want 7 0", c, bus.q, bus.done); end
    end
  endtask

  task automatic test_start_ignored_and_reset();
    issue(2'b01, 4'h9, 4'd8);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    vec++; if (bus.q !== 4'h8) begin errs++; $display("FAIL run_pre: got %h want 8", bus.q); end
    bus.mode = 2'b00; bus.load_val = 4'h0; bus.limit = 4'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    vec++; if (bus.q !== 4'h7 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errs++; $display("FAIL start_in_run: q=%h busy=%b done=%b want 7 1 0", bus.q, bus.busy, bus.done); end
    #2;
    reset = 1'b1;
    #1;
    vec++; if (bus.q !== 4'h0 || bus.busy !== 1'b0) begin
      errs++; $display("FAIL async_reset: q=%h busy=%b want 0 0", bus.q, bus.busy); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vec++; if (bus.q !== 4'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errs++; $display("FAIL post_reset_idle: q=%h busy=%b done=%b", bus.q, bus.busy, bus.done); end
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    test_reset();
    test_up();
    test_down();
    test_pingpong();
    test_gray();
    test_limit_zero();
    test_step_hold();
    test_abort();
    test_start_ignored_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete within 20000 time units");
    $fatal(1);
  end

endmodule
